branch_predict_unit: RTL

Parametrised successor to the M-stage branch resolver. It resolves branch and jump outcomes from the ALU flags, as the existing resolver does, and adds a table of saturating counters that gives fetch a direction prediction. It raises a mispredict flag against the prediction carried down the pipeline, trains the table on resolved branches, and keeps performance counters. It sits between fetch (F-stage lookup) and memory stage (M-stage resolve/update); the hazard unit consumes o_Mispredict.

---
 rtl/branch_predict_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch/jump resolver for the M stage plus a table of saturating counters giving fetch a direction prediction.
// Define BRANCH_GSHARE_EN to xor a non-speculative global history register into both table indices.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 6,
    parameter int CNT_BITS  = 2,
    parameter int PERF_BITS = 32
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [XLEN-1:0]      i_FetchPc_F,
    output logic                 o_PredTaken_F,
    input  logic [XLEN-1:0]      i_Pc_M,
    input  logic                 i_PredTaken_M,
    input  logic                 i_Stall_M,
    input  logic                 i_IsJump_M,
    input  logic                 i_IsBranch_M,
    input  logic [2:0]           i_BranchType_M,
    input  logic                 i_AluASign_M,
    input  logic                 i_AluBSign_M,
    input  logic                 i_AluCarry_M,
    input  logic                 i_AluResZero_M,
    input  logic                 i_AluResNeg_M,
    output logic                 o_TakeBranch,
    output logic                 o_Mispredict,
    output logic [PERF_BITS-1:0] o_BranchCount,
    output logic [PERF_BITS-1:0] o_MispredictCount
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

    logic [CNT_BITS-1:0]  table_q [ENTRIES];
    logic [CNT_BITS-1:0]  table_d [ENTRIES];
    logic [PERF_BITS-1:0] branch_count_q, branch_count_d;
    logic [PERF_BITS-1:0] mispredict_count_q, mispredict_count_d;
    logic [IDX_BITS-1:0]  fetch_idx;
    logic [IDX_BITS-1:0]  update_idx;
    logic                 overflow;
    logic                 cond_met;
    logic                 type_valid;
    logic                 update_en;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{i_FetchPc_F[XLEN-1:IDX_BITS+2], i_FetchPc_F[1:0],
                              i_Pc_M[XLEN-1:IDX_BITS+2], i_Pc_M[1:0]};

`ifdef BRANCH_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    // Update index uses the history as it stands before this update shifts in.
    assign fetch_idx  = i_FetchPc_F[IDX_BITS+1:2] ^ ghr_q;
    assign update_idx = i_Pc_M[IDX_BITS+1:2] ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (update_en) begin
            ghr_d = {ghr_q[IDX_BITS-2:0], o_TakeBranch};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign fetch_idx  = i_FetchPc_F[IDX_BITS+1:2];
    assign update_idx = i_Pc_M[IDX_BITS+1:2];
`endif

    // Asynchronous read: a same-cycle write to this entry is not bypassed.
    assign o_PredTaken_F     = table_q[fetch_idx][CNT_BITS-1];
    assign o_BranchCount     = branch_count_q;
    assign o_MispredictCount = mispredict_count_q;

    always_comb begin
        overflow   = (i_AluASign_M != i_AluBSign_M) && (i_AluBSign_M == i_AluResNeg_M);
        cond_met   = 1'b0;
        type_valid = 1'b1;
        case (i_BranchType_M)
            3'b000:  cond_met = i_AluResZero_M;
            3'b001:  cond_met = !i_AluResZero_M;
            3'b100:  cond_met = i_AluResNeg_M ^ overflow;
            3'b101:  cond_met = !(i_AluResNeg_M ^ overflow) || i_AluResZero_M;
            3'b110:  cond_met = i_AluCarry_M;
            3'b111:  cond_met = !i_AluCarry_M || i_AluResZero_M;
            default: type_valid = 1'b0;
        endcase

        // A branch flag overrides a simultaneous jump flag.
        if (i_IsBranch_M) begin
            o_TakeBranch = type_valid && cond_met;
            o_Mispredict = type_valid && (cond_met != i_PredTaken_M);
        end else begin
            o_TakeBranch = i_IsJump_M;
            o_Mispredict = i_IsJump_M && !i_PredTaken_M;
        end
        update_en = i_IsBranch_M && type_valid && !i_Stall_M;
    end

    always_comb begin
        table_d            = table_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_en) begin
            branch_count_d = branch_count_q + PERF_BITS'(1);
            if (o_TakeBranch) begin
                if (table_q[update_idx] != CNT_MAX) begin
                    table_d[update_idx] = table_q[update_idx] + CNT_BITS'(1);
                end
            end else if (table_q[update_idx] != '0) begin
                table_d[update_idx] = table_q[update_idx] - CNT_BITS'(1);
            end
        end
        if (o_Mispredict && !i_Stall_M) begin
            mispredict_count_d = mispredict_count_q + PERF_BITS'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
